// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared word size, FSM state and request-kind encodings
package mem_responder_pkg;
  localparam int WORD_SIZE = 16;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  typedef enum logic [1:0] {K_READ, K_WRITE, K_ILLEGAL} kind_t;
endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_responder_mem_array: single-port word array, write enable, registered read
module mem_responder_mem_array #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic             rz,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (we) r_mem[addr] <= wdata;
  // rz forces a zero result for reads that fall outside the implemented range
  always_ff @(posedge clk or posedge reset)
    if (reset) rdata <= '0;
    else if (re) rdata <= rz ? '0 : r_mem[addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory responder with one-cycle ack and error flag
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WORD_SIZE  = mem_responder_pkg::WORD_SIZE,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_SIZE-1:0]  req_wdata,
  output logic                  ack,
  output logic [WORD_SIZE-1:0]  rdata,
  output logic                  err,
  output logic                  busy,
  output logic [15:0]           num_access
);
  localparam int AW = $clog2(DEPTH);
  state_t                r_state;
  kind_t                 r_kind;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_SIZE-1:0]  r_wdata;
  kind_t                 w_kind_in, w_kind;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [WORD_SIZE-1:0]  w_wdata;
  logic                  w_idle, w_req, w_go, w_in_range, w_err;
  // In IDLE the live request is used so that LATENCY=0 can complete on the acceptance edge
  always_comb begin
    w_idle     = r_state == S_IDLE;
    w_req      = req_read | req_write;
    w_kind_in  = (req_read && req_write) ? K_ILLEGAL : (req_write ? K_WRITE : K_READ);
    w_kind     = w_idle ? w_kind_in : r_kind;
    w_addr     = w_idle ? req_addr : r_addr;
    w_wdata    = w_idle ? req_wdata : r_wdata;
    w_go       = w_idle ? (w_req && LATENCY == 0) : (r_state == S_WAIT && r_cnt == 4'd0);
    w_in_range = 32'(w_addr) < DEPTH;
    w_err      = w_kind == K_ILLEGAL || !w_in_range;
  end
  mem_responder_mem_array #(.WIDTH(WORD_SIZE), .DEPTH(DEPTH)) u_arr (
    .clk   (clk),
    .reset (reset),
    .we    (w_go && w_kind == K_WRITE && w_in_range),
    .re    (w_go && w_kind == K_READ),
    .rz    (!w_in_range),
    .addr  (w_addr[AW-1:0]),
    .wdata (w_wdata),
    .rdata (rdata)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state    <= S_IDLE;
      r_kind     <= K_READ;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      ack        <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      num_access <= '0;
    end else begin
      ack        <= w_go;
      err        <= w_go && w_err;
      num_access <= num_access + 16'(w_go && !w_err);
      case (r_state)
        S_IDLE:
          if (w_req) begin
            r_kind  <= w_kind_in;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            busy    <= 1'b1;
            r_state <= LATENCY == 0 ? S_ACK : S_WAIT;
            r_cnt   <= LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);
          end
        S_WAIT:
          if (r_cnt == 4'd0) r_state <= S_ACK;
          else r_cnt <= r_cnt - 4'd1;
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vectors for a LATENCY=2 and a LATENCY=0 responder
module tb_mem_responder;
  localparam int LAT_A = 2;
  logic        clk = 1'b0, reset = 1'b1;
  logic        a_rd = 0, a_wr = 0, a_ack, a_err, a_busy;
  logic [15:0] a_addr = 0, a_wdata = 0, a_rdata, a_num;
  logic        b_rd = 0, b_wr = 0, b_ack, b_err, b_busy;
  logic [15:0] b_addr = 0, b_wdata = 0, b_rdata, b_num;
  int          n_vec = 0, n_bad = 0;
  logic        e;
  logic [15:0] rd, num;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .req_read(a_rd), .req_write(a_wr), .req_addr(a_addr),
    .req_wdata(a_wdata), .ack(a_ack), .rdata(a_rdata), .err(a_err), .busy(a_busy),
    .num_access(a_num));

  mem_responder #(.LATENCY(0)) dut_b (
    .clk(clk), .reset(reset), .req_read(b_rd), .req_write(b_wr), .req_addr(b_addr),
    .req_wdata(b_wdata), .ack(b_ack), .rdata(b_rdata), .err(b_err), .busy(b_busy),
    .num_access(b_num));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one full access on dut_a; addr_late replaces req_addr right after acceptance
  task automatic access(input logic r, input logic w, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] addr_late,
                        output logic e_o, output logic [15:0] rd_o, output logic [15:0] num_o);
    int n;
    @(negedge clk);
    a_rd = r; a_wr = w; a_addr = addr; a_wdata = wdata;
    @(posedge clk); #1;
    check("accept_busy", 32'(a_busy), 1);
    check("accept_no_ack", 32'(a_ack), 0);
    a_addr = addr_late;
    n = 0;
    while (!a_ack && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ack_edges", 32'(n), LAT_A);
    e_o = a_err; rd_o = a_rdata; num_o = a_num;
    a_rd = 0; a_wr = 0;
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(a_ack), 0);
    check("busy_drop", 32'(a_busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    dut_a.u_arr.r_mem[3]  = 16'h0F0F;
    dut_a.u_arr.r_mem[4]  = 16'h4444;
    dut_a.u_arr.r_mem[5]  = 16'h0000;
    dut_a.u_arr.r_mem[7]  = 16'h7777;
    dut_a.u_arr.r_mem[9]  = 16'h9999;
    dut_a.u_arr.r_mem[44] = 16'h2C2C;
    dut_b.u_arr.r_mem[0]  = 16'hAAAA;
    dut_b.u_arr.r_mem[1]  = 16'h5555;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(a_ack), 0);
    check("rst_busy", 32'(a_busy), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_err", 32'(a_err), 0);
    check("rst_rdata", 32'(a_rdata), 0);
    check("rst_num", 32'(a_num), 0);

    // LATENCY=0 back-to-back reads, acks two cycles apart
    @(negedge clk);
    b_rd = 1; b_addr = 0;
    @(posedge clk); #1;
    check("l0_ack0", 32'(b_ack), 1);
    check("l0_rdata0", 32'(b_rdata), 32'hAAAA);
    check("l0_err0", 32'(b_err), 0);
    b_addr = 1;
    @(posedge clk); #1;
    check("l0_gap", 32'(b_ack), 0);
    @(posedge clk); #1;
    check("l0_ack1", 32'(b_ack), 1);
    check("l0_rdata1", 32'(b_rdata), 32'h5555);
    b_rd = 0;
    @(posedge clk); #1;
    check("l0_busy", 32'(b_busy), 0);
    check("l0_num", 32'(b_num), 2);

    access(0, 1, 5, 16'h1234, 5, e, rd, num);
    check("wr5_err", 32'(e), 0);
    check("wr5_num", 32'(num), 1);
    check("wr5_mem", 32'(dut_a.u_arr.r_mem[5]), 32'h1234);
    access(1, 0, 5, 0, 5, e, rd, num);
    check("rd5_err", 32'(e), 0);
    check("rd5_rdata", 32'(rd), 32'h1234);
    check("rd5_num", 32'(num), 2);

    access(1, 1, 3, 16'hFFFF, 3, e, rd, num);
    check("both_err", 32'(e), 1);
    check("both_rdata", 32'(rd), 32'h1234);
    check("both_num", 32'(num), 2);
    check("both_mem", 32'(dut_a.u_arr.r_mem[3]), 32'h0F0F);

    access(0, 1, 300, 16'hBEEF, 300, e, rd, num);
    check("oor_wr_err", 32'(e), 1);
    check("oor_wr_num", 32'(num), 2);
    check("oor_wr_alias", 32'(dut_a.u_arr.r_mem[44]), 32'h2C2C);
    access(1, 0, 300, 0, 300, e, rd, num);
    check("oor_rd_err", 32'(e), 1);
    check("oor_rd_rdata", 32'(rd), 0);

    access(1, 0, 4, 0, 7, e, rd, num);
    check("late_addr_rdata", 32'(rd), 32'h4444);
    check("late_addr_num", 32'(num), 3);

    // asynchronous reset while a write sits in WAIT
    @(negedge clk);
    a_wr = 1; a_addr = 9; a_wdata = 16'h7777;
    @(posedge clk); #1;
    check("mid_busy", 32'(a_busy), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(a_busy), 0);
    check("mid_rst_num", 32'(a_num), 0);
    check("mid_rst_rdata", 32'(a_rdata), 0);
    check("mid_rst_ack", 32'(a_ack), 0);
    a_wr = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_mem9", 32'(dut_a.u_arr.r_mem[9]), 32'h9999);
    access(1, 0, 9, 0, 9, e, rd, num);
    check("post_rst_err", 32'(e), 0);
    check("post_rst_rdata", 32'(rd), 32'h9999);
    check("post_rst_num", 32'(num), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory responder on the CPU memory port. It accepts the read and write requests that the multicycle control unit issues during IF and MEM, and inserts a configurable number of wait states. It then completes each access with a one-cycle acknowledge. It sits between the datapath memory port and the unified instruction/data store, and replaces the zero-latency behavioural memory so that the CPU's stall handling can be exercised.

## Interface
- `WORD_SIZE`, 16: data word width; matches the shared `WORD_SIZE` constant.
- `ADDR_WIDTH`, 16: request address width.
- `DEPTH`, 256: number of words implemented. Valid addresses are 0..DEPTH-1.
- `LATENCY`, 2: wait-state cycles between acceptance and acknowledge, range 0..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_read` in 1: read request, level, held by the requester until ack.
- `req_write` in 1: write request, level, held until ack.
- `req_addr` in ADDR_WIDTH: word address.
- `req_wdata` in WORD_SIZE: write data.
- `ack` out 1: one-cycle completion pulse.
- `rdata` out WORD_SIZE: read data, valid when `ack` is high for a read, held until the next read ack.
- `err` out 1: qualifies `ack`; high for an illegal request.
- `busy` out 1: high in WAIT and ACK.
- `num_access` out 16: count of completed non-error accesses; wraps mod 2^16.

## Operation
- FSM states:
  - IDLE: samples the request. `req_read ^ req_write`, or both set, counts as a request. The block captures addr, wdata and kind into internal registers. It goes to WAIT with the counter set to LATENCY-1, or straight to ACK when LATENCY=0.
  - WAIT: decrements the counter and goes to ACK when the counter is 0.
  - ACK: performs the access from the captured fields, drives `ack`=1 for exactly one cycle, then returns to IDLE.
- All outputs are registered, so `ack`, `err` and `rdata` change only on clock edges.
- Read: `rdata` takes mem[addr] in the same edge that raises `ack`.
- Write: mem[addr] is updated at the edge that raises `ack`. A read in the following access returns the new value.
- Both `req_read` and `req_write` high: the request is accepted normally. At ACK it completes with `err`=1, no array access, `rdata` unchanged, and `num_access` unchanged.
- addr ≥ DEPTH: completes with `err`=1. The write is suppressed, or the read returns 0.
- Request inputs that change during WAIT or ACK are ignored, because the captured copy is used.
- The memory array is not reset. Its contents are undefined until written, or preloaded by the bench through hierarchical access.

## Timing
- Reset values: state IDLE, `ack`=0, `err`=0, `busy`=0, `rdata`=0, `num_access`=0, counter=0.
- Acknowledge timing: a request present in IDLE at edge t produces `ack` high in the cycle following edge t+LATENCY. That is LATENCY+1 cycles after acceptance.
- Minimum spacing between acks is LATENCY+2 cycles, because the block spends one cycle in IDLE after each ACK.
- Requester rule: the requester updates or drops its request at the edge where it sees `ack`=1. The block samples again in the IDLE cycle that follows.
- `busy` rises with the acceptance edge and falls with the ACK→IDLE edge.
- Reset asserted mid-access: the block returns to IDLE immediately and all outputs take their reset values. A pending write is discarded and `num_access` is cleared.
- The `num_access` increment and the `ack` rise happen on the same edge. The count wraps from 0xFFFF to 0x0000.

## Structure
- A shared package holds the FSM state encoding (IDLE/WAIT/ACK) and the request-kind enum (READ/WRITE/ILLEGAL). It reuses the existing `WORD_SIZE` from the opcode/constants file.
- One natural sub-module: `mem_array`, a single-port synchronous word array with a write enable and registered read. The FSM, counter and error checks stay in `mem_responder`.

## Test plan
- LATENCY=2: write 0x1234 to addr 5 and check `ack` 3 cycles after acceptance with `err`=0. Then read addr 5 and check `rdata`=0x1234 with `ack` 3 cycles later, and `num_access`=2.
- LATENCY=0: run back-to-back reads of addrs 0 and 1 (preloaded 0xAAAA and 0x5555). Check acks 2 cycles apart and `rdata` 0xAAAA then 0x5555.
- Assert `req_read` and `req_write` together at addr 3, which holds 0x0F0F. Check that `ack` and `err` are 1, mem[3] is still 0x0F0F, `rdata` is unchanged and `num_access` is unchanged.
- Write 0xBEEF to addr 300 (DEPTH=256). Check `err`=1 and that no array word changes. A read of addr 300 returns `rdata`=0 with `err`=1.
- Change `req_addr` from 4 to 7 during WAIT. Check that the access uses addr 4.
- Assert `reset` asynchronously during WAIT of a write of 0x7777 to addr 9. Check that outputs go to reset values immediately, mem[9] is unchanged, and the next request completes normally.
